// File: rtl/mult_sequencer.sv
// Multi-cycle radix-2 shift-add sequencer for MUL/MLA/UMULL/UMLAL/SMULL/SMLAL.
// Runs 32 add steps, then sign-corrects and accumulates, then issues register writebacks and N/Z updates.
module mult_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        set_flags,
    input  logic [3:0]  rd_a,
    input  logic [3:0]  rd_b,
    input  logic [31:0] rm_val,
    input  logic [31:0] rs_val,
    input  logic [31:0] acc_lo,
    input  logic [31:0] acc_hi,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        wr_en_a,
    output logic        wr_en_b,
    output logic [3:0]  wr_addr_a,
    output logic [3:0]  wr_addr_b,
    output logic [31:0] wr_data_a,
    output logic [31:0] wr_data_b,
    output logic        flags_we,
    output logic        flag_n,
    output logic        flag_z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic        long_r;
    logic        accum_r;
    logic        neg_r;
    logic        set_flags_r;
    logic [3:0]  rd_a_r;
    logic [3:0]  rd_b_r;
    logic [63:0] acc_r;
    logic [31:0] mcand_r;
    logic [31:0] mplier_r;
    logic [63:0] prod_r;
    logic [4:0]  cnt_r;

    logic [63:0] step_s;
    logic [63:0] signed_prod_s;
    logic [63:0] acc_add_s;
    logic [63:0] result_s;
    logic        flag_n_s;
    logic        flag_z_s;
    logic        wr_en_b_s;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        logic [31:0] r;
        if (x[31]) begin
            r = ~x + 32'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // 010 and 011 are the only unassigned encodings.
    function automatic logic op_legal(input logic [2:0] o);
        return o[2] | ~o[1];
    endfunction

    // Per-step partial product and the ACC-stage sign fixup / accumulate result.
    always_comb begin
        step_s        = 64'd0;
        signed_prod_s = prod_r;
        acc_add_s     = 64'd0;
        if (mplier_r[cnt_r]) begin
            step_s = {32'd0, mcand_r} << cnt_r;
        end else begin
            step_s = 64'd0;
        end
        if (neg_r) begin
            signed_prod_s = ~prod_r + 64'd1;
        end else begin
            signed_prod_s = prod_r;
        end
        if (!accum_r) begin
            acc_add_s = 64'd0;
        end else if (long_r) begin
            acc_add_s = acc_r;
        end else begin
            acc_add_s = {32'd0, acc_r[31:0]};
        end
        result_s = signed_prod_s + acc_add_s;
        if (long_r) begin
            flag_n_s = result_s[63];
            flag_z_s = (result_s == 64'd0);
        end else begin
            flag_n_s = result_s[31];
            flag_z_s = (result_s[31:0] == 32'd0);
        end
        // A hi/lo collision keeps only the hi write.
        wr_en_b_s = long_r & (rd_a_r != rd_b_r);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            long_r      <= 1'b0;
            accum_r     <= 1'b0;
            neg_r       <= 1'b0;
            set_flags_r <= 1'b0;
            rd_a_r      <= 4'd0;
            rd_b_r      <= 4'd0;
            acc_r       <= 64'd0;
            mcand_r     <= 32'd0;
            mplier_r    <= 32'd0;
            prod_r      <= 64'd0;
            cnt_r       <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            wr_en_a     <= 1'b0;
            wr_en_b     <= 1'b0;
            wr_addr_a   <= 4'd0;
            wr_addr_b   <= 4'd0;
            wr_data_a   <= 32'd0;
            wr_data_b   <= 32'd0;
            flags_we    <= 1'b0;
            flag_n      <= 1'b0;
            flag_z      <= 1'b0;
        end else begin
            done      <= 1'b0;
            illegal   <= 1'b0;
            wr_en_a   <= 1'b0;
            wr_en_b   <= 1'b0;
            wr_addr_a <= 4'd0;
            wr_addr_b <= 4'd0;
            wr_data_a <= 32'd0;
            wr_data_b <= 32'd0;
            flags_we  <= 1'b0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start && op_legal(op)) begin
                        long_r      <= op[2];
                        accum_r     <= op[0];
                        set_flags_r <= set_flags;
                        rd_a_r      <= rd_a;
                        rd_b_r      <= rd_b;
                        acc_r       <= {acc_hi, acc_lo};
                        if (op[2] && op[1]) begin
                            mcand_r  <= abs32(rm_val);
                            mplier_r <= abs32(rs_val);
                            neg_r    <= rm_val[31] ^ rs_val[31];
                        end else begin
                            mcand_r  <= rm_val;
                            mplier_r <= rs_val;
                            neg_r    <= 1'b0;
                        end
                        prod_r  <= 64'd0;
                        cnt_r   <= 5'd0;
                        busy    <= 1'b1;
                        state_r <= S_MULT;
                    end else if (start) begin
                        illegal <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_MULT: begin
                    prod_r <= prod_r + step_s;
                    cnt_r  <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r <= S_ACC;
                    end else begin
                        state_r <= S_MULT;
                    end
                end
                S_ACC: begin
                    prod_r    <= result_s;
                    done      <= 1'b1;
                    wr_en_a   <= 1'b1;
                    wr_addr_a <= rd_a_r;
                    wr_data_a <= long_r ? result_s[63:32] : result_s[31:0];
                    if (wr_en_b_s) begin
                        wr_en_b   <= 1'b1;
                        wr_addr_b <= rd_b_r;
                        wr_data_b <= result_s[31:0];
                    end else begin
                        wr_en_b   <= 1'b0;
                    end
                    flags_we <= set_flags_r;
                    flag_n   <= set_flags_r & flag_n_s;
                    flag_z   <= set_flags_r & flag_z_s;
                    state_r  <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer with hand-computed products.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        set_flags;
    logic [3:0]  rd_a, rd_b;
    logic [31:0] rm_val, rs_val, acc_lo, acc_hi;
    logic        busy, done, illegal;
    logic        wr_en_a, wr_en_b;
    logic [3:0]  wr_addr_a, wr_addr_b;
    logic [31:0] wr_data_a, wr_data_b;
    logic        flags_we, flag_n, flag_z;

    int tests = 0;
    int fails = 0;
    int lat;
    logic busy_first;

    mult_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .set_flags(set_flags),
        .rd_a(rd_a), .rd_b(rd_b), .rm_val(rm_val), .rs_val(rs_val),
        .acc_lo(acc_lo), .acc_hi(acc_hi),
        .busy(busy), .done(done), .illegal(illegal),
        .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
        .flags_we(flags_we), .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one op, scrambles operands after accept, and stops #1 after the done edge.
    task automatic run_op(input logic [2:0] o, input logic sf, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [31:0] m, input logic [31:0] s, input logic [31:0] al, input logic [31:0] ah);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; set_flags = sf; rd_a = ra; rd_b = rb;
        rm_val = m; rs_val = s; acc_lo = al; acc_hi = ah;
        @(posedge clk); #1;
        start = 1'b0; busy_first = busy;
        rm_val = 32'h1234_5678; rs_val = 32'h9ABC_DEF0; acc_lo = 32'h5555_AAAA; acc_hi = 32'hAAAA_5555;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic check_quiet(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_clr"}, 64'(done), 64'd0);
        check({tag, "_busy_clr"}, 64'(busy), 64'd0);
        check({tag, "_wr_clr"}, 64'({wr_en_a, wr_en_b, flags_we}), 64'd0);
        check({tag, "_data_clr"}, 64'({wr_data_a, wr_data_b}), 64'd0);
    endtask

    initial begin
        int dones;
        logic [31:0] cap;
        logic saw;
        rst = 1'b1; start = 1'b0; op = 3'd0; set_flags = 1'b0; rd_a = 4'd0; rd_b = 4'd0;
        rm_val = 32'd0; rs_val = 32'd0; acc_lo = 32'd0; acc_hi = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 64'({busy, done, illegal, wr_en_a, wr_en_b, flags_we, flag_n, flag_z}), 64'd0);
        check("reset_data", 64'({wr_data_a, wr_data_b}), 64'd0);
        rst = 1'b0;

        // MUL 7*6 -> 42
        run_op(3'b000, 1'b1, 4'd3, 4'd9, 32'd7, 32'd6, 32'd0, 32'd0);
        check("mul_lat", 64'(lat), 64'd34);
        check("mul_busy1", 64'(busy_first), 64'd1);
        check("mul_busy34", 64'(busy), 64'd1);
        check("mul_wa", 64'({wr_en_a, wr_addr_a, wr_data_a}), {27'd0, 1'b1, 4'd3, 32'h0000_002A});
        check("mul_wb", 64'(wr_en_b), 64'd0);
        check("mul_flags", 64'({flags_we, flag_n, flag_z}), 64'b100);
        check_quiet("mul");

        // UMULL max*max -> FFFFFFFE_00000001
        run_op(3'b100, 1'b0, 4'd5, 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        check("umull_lat", 64'(lat), 64'd34);
        check("umull_wa", 64'({wr_en_a, wr_addr_a, wr_data_a}), {27'd0, 1'b1, 4'd5, 32'hFFFF_FFFE});
        check("umull_wb", 64'({wr_en_b, wr_addr_b, wr_data_b}), {27'd0, 1'b1, 4'd4, 32'h0000_0001});
        check("umull_fwe", 64'(flags_we), 64'd0);
        check_quiet("umull");

        // SMULL -2*3 -> -6
        run_op(3'b110, 1'b1, 4'd1, 4'd2, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
        check("smull_hi", 64'(wr_data_a), 64'hFFFF_FFFF);
        check("smull_lo", 64'(wr_data_b), 64'hFFFF_FFFA);
        check("smull_flags", 64'({flags_we, flag_n, flag_z}), 64'b110);
        check_quiet("smull");

        // SMLAL -2*3 + 6 -> 0
        run_op(3'b111, 1'b1, 4'd1, 4'd2, 32'hFFFF_FFFE, 32'd3, 32'd6, 32'd0);
        check("smlal_data", {wr_data_a, wr_data_b}, 64'd0);
        check("smlal_en", 64'({wr_en_a, wr_en_b}), 64'b11);
        check("smlal_flags", 64'({flags_we, flag_n, flag_z}), 64'b101);
        check_quiet("smlal");

        // MLA 0*5 + 0, flags on then off
        run_op(3'b001, 1'b1, 4'd6, 4'd0, 32'd0, 32'd5, 32'd0, 32'd0);
        check("mla0_data", 64'({wr_en_a, wr_data_a}), {31'd0, 1'b1, 32'd0});
        check("mla0_flags", 64'({flags_we, flag_n, flag_z}), 64'b101);
        check_quiet("mla0");
        run_op(3'b001, 1'b0, 4'd6, 4'd0, 32'd0, 32'd5, 32'd0, 32'd0);
        check("mla0_nf", 64'(flags_we), 64'd0);
        check_quiet("mla0nf");

        // MLA 3*4 + 10 = 22; acc_hi must not leak in
        run_op(3'b001, 1'b0, 4'd8, 4'd0, 32'd3, 32'd4, 32'd10, 32'h0000_DEAD);
        check("mla_data", 64'(wr_data_a), 64'h16);
        check("mla_wb", 64'(wr_en_b), 64'd0);
        check_quiet("mla");

        // UMLAL with rd_a==rd_b: 6 + 1_FFFFFFFF = 2_00000005, hi only
        run_op(3'b101, 1'b0, 4'd7, 4'd7, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'd1);
        check("umlal_wa", 64'({wr_en_a, wr_addr_a, wr_data_a}), {27'd0, 1'b1, 4'd7, 32'h0000_0002});
        check("umlal_wb", 64'(wr_en_b), 64'd0);
        check_quiet("umlal");

        // SMULL 0x80000000 * 2 -> FFFFFFFF_00000000
        run_op(3'b110, 1'b1, 4'd10, 4'd11, 32'h8000_0000, 32'd2, 32'd0, 32'd0);
        check("smull_min", {wr_data_a, wr_data_b}, 64'hFFFF_FFFF_0000_0000);
        check("smull_min_f", 64'({flag_n, flag_z}), 64'b10);
        check_quiet("smullmin");

        // MUL 2^16*2^16: low word 0 -> Z set on short op
        run_op(3'b000, 1'b1, 4'd12, 4'd0, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0);
        check("mul_z", 64'({wr_data_a, flag_n, flag_z}), {30'd0, 32'd0, 2'b01});
        check_quiet("mulz");

        // Illegal ops
        @(negedge clk); start = 1'b1; op = 3'b010;
        @(posedge clk); #1; start = 1'b0;
        check("ill_pulse", 64'({illegal, busy, wr_en_a, wr_en_b}), 64'b1000);
        @(posedge clk); #1;
        check("ill_clr", 64'({illegal, busy}), 64'd0);
        @(negedge clk); start = 1'b1; op = 3'b011;
        @(posedge clk); #1; start = 1'b0;
        check("ill_011", 64'({illegal, busy}), 64'b10);
        @(posedge clk); #1;

        // start while busy is ignored
        @(negedge clk); start = 1'b1; op = 3'b000; set_flags = 1'b0; rd_a = 4'd3;
        rm_val = 32'd7; rs_val = 32'd6;
        @(posedge clk); #1; start = 1'b0;
        dones = 0; cap = 32'd0;
        for (int i = 1; i < 90; i++) begin
            if (i == 5) begin
                start = 1'b1; rm_val = 32'd1; rs_val = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                cap = wr_data_a;
            end
        end
        start = 1'b0;
        check("busy_ign_cnt", 64'(dones), 64'd1);
        check("busy_ign_data", 64'(cap), 64'h2A);

        // Reset at k+10 of a UMULL
        @(negedge clk); start = 1'b1; op = 3'b100; rd_a = 4'd5; rd_b = 4'd4;
        rm_val = 32'hFFFF_FFFF; rs_val = 32'hFFFF_FFFF;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outs", 64'({busy, done, wr_en_a, wr_en_b, flags_we}), 64'd0);
        check("rst_mid_data", 64'({wr_data_a, wr_data_b}), 64'd0);
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || wr_en_a !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        check("rst_no_done", 64'(saw), 64'd0);

        run_op(3'b000, 1'b1, 4'd3, 4'd0, 32'd7, 32'd6, 32'd0, 32'd0);
        check("post_rst_lat", 64'(lat), 64'd34);
        check("post_rst_data", 64'({wr_en_a, wr_addr_a, wr_data_a}), {27'd0, 1'b1, 4'd3, 32'h0000_002A});
        check_quiet("postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
